vua_lexer: RTL and testbench
============================

# vua_lexer

Hardware tokenizer that sits directly upstream of the expression-compilation stage. It consumes a byte stream of source text and emits one token per handshake: kind, numeric or identifier-hash value, and source line number. It handles decimal literals, identifiers, the `or` keyword, single- and two-character operators, and end-of-file. The downstream stage relies on the line number to decide whether `(`, `[` or `.` continues an expression.

## Interface
- `NUM_W`, 64: width of literal value; decimal accumulation wraps mod 2^NUM_W.
- `LINE_W`, 16: line counter width; wraps to 0 on overflow.
- `ID_MAX`, 32: maximum identifier length in bytes.

- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: source byte valid.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `in_data` in 8: source byte (ASCII).
- `in_last` in 1: marks the final byte of the source.
- `tok_valid` out 1: token register full.
- `tok_ready` in 1: token accepted when `tok_valid && tok_ready`.
- `tok_kind` out 5: token kind (enum in the package).
- `tok_value` out NUM_W: literal value; FNV-1a-32 hash (zero-extended) for identifiers; offending byte for ERR.
- `tok_line` out LINE_W: line of the token's first byte (first line = 1).

## Operation
- **States:** IDLE, NUM, IDENT, OP2, FLUSH, DONE.
- **IDLE, whitespace:** space, tab and CR are consumed and dropped. LF is consumed and increments the line counter.
- **IDLE, digit:** `acc = digit`, go to NUM.
- **IDLE, letter or `_`:** start the hash and length counter, go to IDENT.
- **IDLE, op-start byte** (`+ - * / = ! < > & |`): latch it, go to OP2.
- **IDLE, single-char token** (`( ) [ ] . ,`): emit it directly.
- **IDLE, any other byte:** emit ERR with `value = byte`.
- **NUM:** on a digit, `acc = acc*10 + d` (wrapping).
- **IDENT:** on letter, digit or `_`, update the hash and increment the length (saturating at ID_MAX+1).
- **Termination by peek:** a non-continuing byte ends NUM or IDENT without being consumed (`in_ready = 0` that cycle). The token is emitted, the FSM returns to IDLE, and the byte is reprocessed next cycle. Upstream must hold `in_data` stable while `in_valid && !in_ready`.
- **Identifier results:** length > ID_MAX gives ERR with `value = ID_MAX+1`. An identifier equal to `or` gives OR_UNWRAP.
- **OP2 pairs:** `++ -- += -= *= /= == != <= >= && ||` consume the second byte and emit the pair.
- **OP2 otherwise:** peek, emit the single-char op, return to IDLE. A lone `&` or `|` gives ERR.
- **End of input:** consuming a byte with `in_last` sets `eof_seen`. Any open NUM/IDENT/OP2 token completes, then FLUSH emits EOF. The FSM then enters DONE with `in_ready = 0` until `rst`.
- **Backpressure:** the token register holds while `tok_valid && !tok_ready`. Any transition that would load a token stalls (`in_ready = 0`, state held). Loading is allowed in the same cycle the register drains.
- **Reset values:** `tok_valid = 0`, `in_ready = 0`, `tok_kind = EOF`, `tok_value = 0`, `tok_line = 1`, line counter = 1, state IDLE. A reset mid-token discards all partial state.

## Timing
- Sustains 1 byte per cycle. Each NUM, IDENT or OP2 token terminated by peek costs one extra cycle.
- `tok_valid` rises one cycle after the terminating byte is seen, or after the last byte of a pair or single-char token is consumed.
- `in_ready` is combinational from state, `in_data`, and the token-register-free condition. No combinational path exists from `in_valid` to `tok_valid`.
- The EOF token appears one cycle after the final token is loaded, or after the `in_last` byte is consumed if no token is open.

## Structure
- **Package `vua_token_pkg`:** `tok_kind_e` (IDENT, NUMBER, OPAREN, CPAREN, OSBRACE, CSBRACE, DOT, COMMA, ADD, SUB, MUL, DIV, ASSIGN, ADD_ASSIGN, SUB_ASSIGN, MUL_ASSIGN, DIV_ASSIGN, INC, DEC, EQ, NE, NOT, LT, GT, LE, GE, L_AND, L_OR, OR_UNWRAP, ERR, EOF), the FNV-1a offset/prime constants, and a character-class function. The downstream stage imports the same package.
- **Sub-module `vua_lex_out_reg`:** one-entry valid/ready token register.

## Test plan
- Input `a+=12` with `in_last` on `2` -> IDENT (hash of "a", line 1), ADD_ASSIGN, NUMBER 12, EOF; no gaps with `tok_ready = 1`.
- Input `x\n(` -> IDENT line 1, OPAREN line 2, EOF line 2.
- Input `-5||or` -> SUB, NUMBER 5, L_OR, OR_UNWRAP, EOF.
- Input `&$` -> ERR value 0x26, ERR value 0x24, EOF.
- Input `99999999999999999999` (20 digits) -> NUMBER equal to that value mod 2^64 (`0x6BC75E2D630FFFFF`).
- Hold `tok_ready = 0` for 10 cycles mid-stream -> `in_ready` low, token and state held, nothing lost. Assert `rst` mid-IDENT -> all outputs take their reset values next cycle, and the following tokens come from fresh input only.

Source files
------------

// File: rtl/vua_token_pkg.sv
// Token kinds, character classes and FNV-1a helpers shared by the lexer and
// the downstream expression compiler.
package vua_token_pkg;

  typedef enum logic [4:0] {
    IDENT, NUMBER, OPAREN, CPAREN, OSBRACE, CSBRACE, DOT, COMMA,
    ADD, SUB, MUL, DIV, ASSIGN, ADD_ASSIGN, SUB_ASSIGN, MUL_ASSIGN,
    DIV_ASSIGN, INC, DEC, EQ, NE, NOT, LT, GT, LE, GE, L_AND, L_OR,
    OR_UNWRAP, ERR, EOF
  } tok_kind_e;

  typedef enum logic [2:0] {
    CC_WS, CC_LF, CC_DIGIT, CC_ALPHA, CC_OP, CC_SINGLE, CC_OTHER
  } char_class_e;

  localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME  = 32'h01000193;

  function automatic char_class_e char_class(input logic [7:0] c);
    if (c == 8'h20 || c == 8'h09 || c == 8'h0D) return CC_WS;
    if (c == 8'h0A) return CC_LF;
    if (c >= "0" && c <= "9") return CC_DIGIT;
    if ((c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || c == "_") return CC_ALPHA;
    case (c)
      "+", "-", "*", "/", "=", "!", "<", ">", "&", "|": return CC_OP;
      "(", ")", "[", "]", ".", ",":                    return CC_SINGLE;
      default:                                         return CC_OTHER;
    endcase
  endfunction

  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] c);
    return (h ^ {24'h0, c}) * FNV_PRIME;
  endfunction

  function automatic tok_kind_e single_kind(input logic [7:0] c);
    case (c)
      "(":     return OPAREN;
      ")":     return CPAREN;
      "[":     return OSBRACE;
      "]":     return CSBRACE;
      ".":     return DOT;
      ",":     return COMMA;
      default: return ERR;
    endcase
  endfunction

  function automatic tok_kind_e op1_kind(input logic [7:0] c);
    case (c)
      "+":     return ADD;
      "-":     return SUB;
      "*":     return MUL;
      "/":     return DIV;
      "=":     return ASSIGN;
      "!":     return NOT;
      "<":     return LT;
      ">":     return GT;
      default: return ERR;
    endcase
  endfunction

  // EOF doubles as the "not a pair" answer; no real pair ever yields it.
  function automatic tok_kind_e op_pair(input logic [7:0] a, input logic [7:0] b);
    case ({a, b})
      "++":    return INC;
      "--":    return DEC;
      "+=":    return ADD_ASSIGN;
      "-=":    return SUB_ASSIGN;
      "*=":    return MUL_ASSIGN;
      "/=":    return DIV_ASSIGN;
      "==":    return EQ;
      "!=":    return NE;
      "<=":    return LE;
      ">=":    return GE;
      "&&":    return L_AND;
      "||":    return L_OR;
      default: return EOF;
    endcase
  endfunction

endpackage

// File: rtl/vua_lexer_if.sv
// Byte-in / token-out handshake bundle between the source feeder, the lexer
// and the expression compiler.
interface vua_lexer_if
  import vua_token_pkg::*;
#(
  parameter int NUM_W  = 64,
  parameter int LINE_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              tok_valid;
  logic              tok_ready;
  tok_kind_e         tok_kind;
  logic [NUM_W-1:0]  tok_value;
  logic [LINE_W-1:0] tok_line;

  modport slave (
    input  in_valid, in_data, in_last, tok_ready,
    output in_ready, tok_valid, tok_kind, tok_value, tok_line
  );

  modport master (
    output in_valid, in_data, in_last, tok_ready,
    input  in_ready, tok_valid, tok_kind, tok_value, tok_line
  );
endinterface

// File: rtl/vua_lex_out_reg.sv
// One-entry valid/ready token register; free_o tells the lexer it may load
// this cycle (empty, or draining right now).
module vua_lex_out_reg
  import vua_token_pkg::*;
#(
  parameter int NUM_W  = 64,
  parameter int LINE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  tok_kind_e         kind_i,
  input  logic [NUM_W-1:0]  value_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              ready_i,
  output logic              valid_o,
  output tok_kind_e         kind_o,
  output logic [NUM_W-1:0]  value_o,
  output logic [LINE_W-1:0] line_o,
  output logic              free_o
);
  logic              valid_q;
  tok_kind_e         kind_q;
  logic [NUM_W-1:0]  value_q;
  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      kind_q  <= EOF;
      value_q <= '0;
      line_q  <= LINE_W'(1);
    end else if (load_i) begin
      valid_q <= 1'b1;
      kind_q  <= kind_i;
      value_q <= value_i;
      line_q  <= line_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign kind_o  = kind_q;
  assign value_o = value_q;
  assign line_o  = line_q;
endmodule

// File: rtl/vua_lexer.sv
// Byte-stream tokenizer: numbers, identifiers (FNV-1a hashed), operators and
// EOF, one token per handshake, tagged with the line of the token's first byte.
module vua_lexer
  import vua_token_pkg::*;
#(
  parameter int NUM_W  = 64,
  parameter int LINE_W = 16,
  parameter int ID_MAX = 32
) (
  input logic        clk,
  input logic        rst,
  vua_lexer_if.slave bus
);
  localparam int               LEN_W   = $clog2(ID_MAX + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(ID_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_NUM, S_IDENT, S_OP2, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              eof_q, eof_d;
  logic [NUM_W-1:0]  acc_q, acc_d;
  logic [31:0]       hash_q, hash_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              or_q, or_d;
  logic [7:0]        op_q, op_d;

  logic              rdy, fire, free, load;
  tok_kind_e         ld_kind, pair_k, op1_k, id_kind;
  logic [NUM_W-1:0]  ld_value, id_value, acc_next, op1_value;
  logic [7:0]        b;
  char_class_e       cc;

  assign b         = bus.in_data;
  assign cc        = char_class(b);
  assign fire      = bus.in_valid && rdy;
  assign pair_k    = op_pair(op_q, b);
  assign op1_k     = op1_kind(op_q);
  assign op1_value = (op1_k == ERR) ? NUM_W'(op_q) : '0;
  assign acc_next  = acc_q * NUM_W'(10) + NUM_W'(b[3:0]);
  assign bus.in_ready = rdy && !rst;

  // Identifier verdict: over-long wins over keyword match.
  always_comb begin
    id_kind  = IDENT;
    id_value = NUM_W'(hash_q);
    if (len_q == LEN_SAT) begin
      id_kind  = ERR;
      id_value = NUM_W'(ID_MAX + 1);
    end else if (or_q && len_q == LEN_W'(2)) begin
      id_kind = OR_UNWRAP;
    end
  end

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    eof_d    = eof_q;
    acc_d    = acc_q;
    hash_d   = hash_q;
    len_d    = len_q;
    or_d     = or_q;
    op_d     = op_q;
    rdy      = 1'b0;
    load     = 1'b0;
    ld_kind  = EOF;
    ld_value = '0;
    case (state_q)
      S_IDLE: begin
        rdy = (cc inside {CC_SINGLE, CC_OTHER}) ? free : 1'b1;
        if (fire) begin
          if (bus.in_last) begin
            eof_d   = 1'b1;
            state_d = S_FLUSH;
          end
          case (cc)
            CC_LF:    line_d = line_q + 1'b1;
            CC_DIGIT: begin
              acc_d   = NUM_W'(b[3:0]);
              state_d = S_NUM;
            end
            CC_ALPHA: begin
              hash_d  = fnv_step(FNV_OFFSET, b);
              len_d   = LEN_W'(1);
              or_d    = (b == "o");
              state_d = S_IDENT;
            end
            CC_OP: begin
              op_d    = b;
              state_d = S_OP2;
            end
            CC_SINGLE: begin
              load    = 1'b1;
              ld_kind = single_kind(b);
            end
            CC_OTHER: begin
              load     = 1'b1;
              ld_kind  = ERR;
              ld_value = NUM_W'(b);
            end
            default: ;
          endcase
        end
      end
      S_NUM: begin
        if (eof_q) begin
          if (free) begin
            load     = 1'b1;
            ld_kind  = NUMBER;
            ld_value = acc_q;
            state_d  = S_FLUSH;
          end
        end else if (cc == CC_DIGIT) begin
          rdy = 1'b1;
          if (fire) begin
            acc_d = acc_next;
            eof_d = bus.in_last;
          end
        end else if (bus.in_valid && free) begin
          load     = 1'b1;
          ld_kind  = NUMBER;
          ld_value = acc_q;
          state_d  = S_IDLE;
        end
      end
      S_IDENT: begin
        if (eof_q) begin
          if (free) begin
            load     = 1'b1;
            ld_kind  = id_kind;
            ld_value = id_value;
            state_d  = S_FLUSH;
          end
        end else if (cc inside {CC_ALPHA, CC_DIGIT}) begin
          rdy = 1'b1;
          if (fire) begin
            hash_d = fnv_step(hash_q, b);
            len_d  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
            or_d   = or_q && (len_q == LEN_W'(1)) && (b == "r");
            eof_d  = bus.in_last;
          end
        end else if (bus.in_valid && free) begin
          load     = 1'b1;
          ld_kind  = id_kind;
          ld_value = id_value;
          state_d  = S_IDLE;
        end
      end
      S_OP2: begin
        if (eof_q) begin
          if (free) begin
            load     = 1'b1;
            ld_kind  = op1_k;
            ld_value = op1_value;
            state_d  = S_FLUSH;
          end
        end else if (pair_k != EOF) begin
          rdy = free;
          if (fire) begin
            load    = 1'b1;
            ld_kind = pair_k;
            eof_d   = bus.in_last;
            state_d = bus.in_last ? S_FLUSH : S_IDLE;
          end
        end else if (bus.in_valid && free) begin
          load     = 1'b1;
          ld_kind  = op1_k;
          ld_value = op1_value;
          state_d  = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (free) begin
          load    = 1'b1;
          state_d = S_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      line_q  <= LINE_W'(1);
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      eof_q   <= eof_d;
    end
  end

  // Token-building scratch is always re-seeded on token start, so no reset.
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    hash_q <= hash_d;
    len_q  <= len_d;
    or_q   <= or_d;
    op_q   <= op_d;
  end

  vua_lex_out_reg #(.NUM_W(NUM_W), .LINE_W(LINE_W)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .kind_i  (ld_kind),
    .value_i (ld_value),
    .line_i  (line_q),
    .ready_i (bus.tok_ready),
    .valid_o (bus.tok_valid),
    .kind_o  (bus.tok_kind),
    .value_o (bus.tok_value),
    .line_o  (bus.tok_line),
    .free_o  (free)
  );
endmodule

// File: tb/tb_vua_lexer.sv
// Directed bench for vua_lexer: expected tokens queued as source is driven,
// popped and compared whenever a token handshake occurs.
module tb_vua_lexer;
  import vua_token_pkg::*;

  localparam int NUM_W  = 64;
  localparam int LINE_W = 16;
  localparam int ID_MAX = 32;

  typedef struct {
    tok_kind_e   kind;
    logic [63:0] value;
    logic [15:0] line;
    bit          chk_val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  vua_lexer_if #(.NUM_W(NUM_W), .LINE_W(LINE_W)) bus ();

  vua_lexer #(.NUM_W(NUM_W), .LINE_W(LINE_W), .ID_MAX(ID_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] fnv(input string s);
    logic [31:0] h = 32'h811C9DC5;
    for (int i = 0; i < s.len(); i++) h = (h ^ {24'h0, s[i]}) * 32'h01000193;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tok(input tok_kind_e k, input logic [63:0] v, input logic [15:0] ln,
                            input bit cv);
    exp_t e;
    e.kind = k; e.value = v; e.line = ln; e.chk_val = cv;
    sb.push_back(e);
  endtask

  // Token monitor: handshake completes at the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.tok_valid && bus.tok_ready) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_token: observed kind %0d expected none", bus.tok_kind);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tok_kind", 64'(bus.tok_kind), 64'(e.kind));
        chk("tok_line", 64'(bus.tok_line), 64'(e.line));
        if (e.chk_val) chk("tok_value", bus.tok_value, e.value);
      end
    end
  end

  task automatic send_byte(input logic [7:0] c, input logic last);
    bit acc = 1'b0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    bus.in_last  = last;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 300) begin
        tests++;
        fails++;
        $error("FAIL send_timeout: observed in_ready 0 expected 1 (byte 0x%0h)", c);
        break;
      end
    end
  endtask

  task automatic send_str(input string s, input bit mark_last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], mark_last && (i == s.len() - 1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    string zs32, zs33;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.tok_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tok_valid", 64'(bus.tok_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_tok_kind", 64'(bus.tok_kind), 64'(EOF));
    chk("rst_tok_value", bus.tok_value, 64'd0);
    chk("rst_tok_line", 64'(bus.tok_line), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // a+=12
    expect_tok(IDENT, 64'hE40C292C, 16'd1, 1'b1);
    expect_tok(ADD_ASSIGN, 64'd0, 16'd1, 1'b0);
    expect_tok(NUMBER, 64'd12, 16'd1, 1'b1);
    expect_tok(EOF, 64'd0, 16'd1, 1'b1);
    send_str("a+=12", 1'b1);
    wait_drain();

    // x LF (
    reset_dut();
    expect_tok(IDENT, 64'(fnv("x")), 16'd1, 1'b1);
    expect_tok(OPAREN, 64'd0, 16'd2, 1'b0);
    expect_tok(EOF, 64'd0, 16'd2, 1'b1);
    send_str("x\n(", 1'b1);
    wait_drain();

    // -5||or
    reset_dut();
    expect_tok(SUB, 64'd0, 16'd1, 1'b0);
    expect_tok(NUMBER, 64'd5, 16'd1, 1'b1);
    expect_tok(L_OR, 64'd0, 16'd1, 1'b0);
    expect_tok(OR_UNWRAP, 64'd0, 16'd1, 1'b0);
    expect_tok(EOF, 64'd0, 16'd1, 1'b1);
    send_str("-5||or", 1'b1);
    wait_drain();

    // &$
    reset_dut();
    expect_tok(ERR, 64'h26, 16'd1, 1'b1);
    expect_tok(ERR, 64'h24, 16'd1, 1'b1);
    expect_tok(EOF, 64'd0, 16'd1, 1'b1);
    send_str("&$", 1'b1);
    wait_drain();

    // 20 nines wraps mod 2^64
    reset_dut();
    expect_tok(NUMBER, 64'h6BC75E2D630FFFFF, 16'd1, 1'b1);
    expect_tok(EOF, 64'd0, 16'd1, 1'b1);
    send_str("99999999999999999999", 1'b1);
    wait_drain();

    // Every pair, peeked singles and single-char tokens
    reset_dut();
    expect_tok(EQ, 0, 1, 0);         expect_tok(NE, 0, 1, 0);
    expect_tok(LE, 0, 1, 0);         expect_tok(GE, 0, 1, 0);
    expect_tok(L_AND, 0, 1, 0);      expect_tok(INC, 0, 1, 0);
    expect_tok(DEC, 0, 1, 0);        expect_tok(MUL_ASSIGN, 0, 1, 0);
    expect_tok(DIV_ASSIGN, 0, 1, 0); expect_tok(SUB_ASSIGN, 0, 1, 0);
    expect_tok(LT, 0, 1, 0);         expect_tok(GT, 0, 1, 0);
    expect_tok(CPAREN, 0, 1, 0);     expect_tok(OSBRACE, 0, 1, 0);
    expect_tok(CSBRACE, 0, 1, 0);    expect_tok(DOT, 0, 1, 0);
    expect_tok(COMMA, 0, 1, 0);      expect_tok(DIV, 0, 1, 0);
    expect_tok(EOF, 0, 1, 1);
    send_str("==!=<=>=&&++--*=/=-=<>)[].,/", 1'b1);
    wait_drain();

    // Identifier length boundary: ID_MAX ok, ID_MAX+1 is ERR
    reset_dut();
    zs32 = "";
    for (int i = 0; i < ID_MAX; i++) zs32 = {zs32, "z"};
    zs33 = {zs32, "z"};
    expect_tok(IDENT, 64'(fnv(zs32)), 16'd1, 1'b1);
    expect_tok(ERR, 64'(ID_MAX + 1), 16'd1, 1'b1);
    expect_tok(EOF, 64'd0, 16'd1, 1'b1);
    send_str({zs32, " ", zs33, " "}, 1'b1);
    wait_drain();

    // Backpressure: hold tok_ready low for 10 cycles mid-stream
    reset_dut();
    bus.tok_ready = 1'b0;
    expect_tok(IDENT, 64'(fnv("ab")), 16'd1, 1'b1);
    expect_tok(ADD, 64'd0, 16'd1, 1'b0);
    expect_tok(NUMBER, 64'd1, 16'd1, 1'b1);
    expect_tok(EOF, 64'd0, 16'd1, 1'b1);
    fork
      send_str("ab+1", 1'b1);
      begin
        repeat (6) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
          chk("bp_tok_valid", 64'(bus.tok_valid), 64'd1);
          chk("bp_tok_kind", 64'(bus.tok_kind), 64'(IDENT));
          chk("bp_tok_value", bus.tok_value, 64'(fnv("ab")));
        end
        @(posedge clk);
        #1;
        bus.tok_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-identifier discards partial token and line count
    reset_dut();
    expect_tok(IDENT, 64'(fnv("x")), 16'd2, 1'b1);
    send_str("\nx qw", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tok_valid", 64'(bus.tok_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_tok_kind", 64'(bus.tok_kind), 64'(EOF));
    chk("mid_rst_tok_value", bus.tok_value, 64'd0);
    chk("mid_rst_tok_line", 64'(bus.tok_line), 64'd1);
    chk("mid_rst_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_tok(NUMBER, 64'd7, 16'd1, 1'b1);
    expect_tok(EOF, 64'd0, 16'd1, 1'b1);
    send_str("7", 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
